uart_wb_loader: RTL and testbench

- Wishbone bus master that turns the byte stream from uart_bridge (o_byte_rx_data/o_byte_rx_valid) into 32-bit word writes on the system bus.
- Sits upstream of WB_slave_arbiter, alongside picorv32_wb as a second master behind a master mux.
- Used to download program images into BRAM/SDRAM over serial.
- Holds the CPU in reset (o_cpu_hold) while loading and releases it on command.

---
 rtl/uart_wb_loader_if.sv | 24 ++
 rtl/uart_wb_loader.sv | 173 +++++++++++++++++
 tb/tb_uart_wb_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_wb_loader_if.sv
// Byte stream and Wishbone write-master signal bundle for uart_wb_loader.
// master: the loader; slave: the byte source plus bus slave side.
interface uart_wb_loader_if;
    logic [7:0]  byte_rx_data;
    logic        byte_rx_valid;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_sel;
    logic        wb_stall;
    logic        wb_ack;

    modport master (
        input  byte_rx_data, byte_rx_valid, wb_stall, wb_ack,
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_data, wb_sel
    );

    modport slave (
        output byte_rx_data, byte_rx_valid, wb_stall, wb_ack,
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_data, wb_sel
    );
endinterface

// File: rtl/uart_wb_loader.sv
// Serial frame loader: turns SYNC/CMD/ADDR/LEN/DATA byte frames into 32-bit
// Wishbone word writes and controls the CPU hold line.
//
// byte FSM state | meaning
// S_IDLE         | hunting for the 0xA5 sync byte
// S_CMD          | waiting for the command byte
// S_ADDR         | collecting the 4 little-endian address bytes
// S_LEN          | collecting the 2 little-endian word-count bytes
// S_DATA         | assembling data words; after the last one, waiting for its ack
//
// bus FSM state  | meaning
// B_IDLE         | no cycle on the bus
// B_REQ          | cyc and stb high, waiting for the slave to drop stall
// B_WAIT         | stb accepted, cyc high until ack
module uart_wb_loader #(
    parameter int BYTE_TIMEOUT  = 1_000_000,
    parameter int ACK_TIMEOUT   = 1024,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_wb_loader_if.master  bus,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic [1:0]        o_err
);
    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int AT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [BT_W-1:0] BT_LOAD = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [AT_W-1:0] AT_LOAD = AT_W'(ACK_TIMEOUT - 1);
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA} byte_state_t;
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} bus_state_t;

    byte_state_t state, state_nxt;
    bus_state_t  bstate, bstate_nxt;

    logic [1:0]      byte_cnt;
    logic [23:0]     shift;
    logic [15:0]     words_left;
    logic [BT_W-1:0] byte_tmr;
    logic [AT_W-1:0] ack_tmr;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic            cpu_hold;
    logic [1:0]      err;

    logic        rx;
    logic [7:0]  rxd;
    logic        bus_active, accepted, bus_ack, bus_to, byte_to;
    logic        word_done, overrun, handoff, abort;
    logic [15:0] len_word;

    assign rx         = bus.byte_rx_valid;
    assign rxd        = bus.byte_rx_data;
    assign bus_active = (bstate != B_IDLE);
    assign accepted   = (bstate == B_REQ) && !bus.wb_stall;
    assign bus_ack    = (accepted || (bstate == B_WAIT)) && bus.wb_ack;
    // A received byte beats a byte timeout; an ack beats a bus timeout.
    assign bus_to     = bus_active && !bus_ack && (ack_tmr == '0);
    assign byte_to    = (state != S_IDLE) && !rx && (byte_tmr == '0);
    assign word_done  = (state == S_DATA) && rx && (words_left != 16'd0) && (byte_cnt == 2'd3);
    assign overrun    = word_done && bus_active;
    assign handoff    = word_done && !bus_active;
    assign abort      = byte_to || bus_to || overrun;
    assign len_word   = {rxd, shift[23:16]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            bstate <= B_IDLE;
        end else begin
            state  <= state_nxt;
            bstate <= bstate_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bstate_nxt = bstate;
        case (state)
            S_IDLE:  if (rx && rxd == SYNC) state_nxt = S_CMD;
            S_CMD:   if (rx) state_nxt = (rxd == CMD_WRITE) ? S_ADDR : S_IDLE;
            S_ADDR:  if (rx && byte_cnt == 2'd3) state_nxt = S_LEN;
            S_LEN:   if (rx && byte_cnt == 2'd1) state_nxt = (len_word == 16'd0) ? S_IDLE : S_DATA;
            S_DATA:  if (words_left == 16'd0 && (bus_ack || !bus_active)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        case (bstate)
            B_IDLE:  if (handoff) bstate_nxt = B_REQ;
            B_REQ:   if (accepted) bstate_nxt = bus.wb_ack ? B_IDLE : B_WAIT;
            B_WAIT:  if (bus.wb_ack) bstate_nxt = B_IDLE;
            default: bstate_nxt = B_IDLE;
        endcase
        if (abort) begin
            state_nxt  = S_IDLE;
            bstate_nxt = B_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt   <= '0;
            shift      <= '0;
            words_left <= '0;
            byte_tmr   <= '0;
            ack_tmr    <= '0;
            addr       <= '0;
            data       <= '0;
            cpu_hold   <= HOLD_AT_RESET;
            err        <= '0;
        end else begin
            if (state_nxt != state)
                byte_cnt <= '0;
            else if (rx && (state == S_ADDR || state == S_LEN || state == S_DATA))
                byte_cnt <= byte_cnt + 2'd1;

            // Only the last three bytes are ever needed alongside the current one.
            if (rx)
                shift <= {rxd, shift[23:8]};

            if (state == S_ADDR && rx && byte_cnt == 2'd3)
                addr <= {rxd, shift[23:2], 2'b00};
            else if (bus_ack)
                addr <= addr + 32'd4;

            if (state == S_LEN && rx && byte_cnt == 2'd1)
                words_left <= len_word;
            else if (handoff)
                words_left <= words_left - 16'd1;

            if (handoff)
                data <= {rxd, shift};

            if (rx)
                byte_tmr <= BT_LOAD;
            else if (state != S_IDLE && byte_tmr != '0)
                byte_tmr <= byte_tmr - 1'b1;

            if (handoff)
                ack_tmr <= AT_LOAD;
            else if (bus_active && ack_tmr != '0)
                ack_tmr <= ack_tmr - 1'b1;

            if (state == S_CMD && rx) begin
                if (rxd == CMD_WRITE)
                    cpu_hold <= 1'b1;
                else if (rxd == CMD_RUN)
                    cpu_hold <= 1'b0;
            end

            if (abort)
                err <= (bus_to || overrun) ? 2'd3 : 2'd2;
            else if (state == S_CMD && rx && rxd != CMD_WRITE && rxd != CMD_RUN)
                err <= 2'd1;
            else if (state == S_IDLE && rx && rxd == SYNC)
                err <= 2'd0;
        end
    end

    assign bus.wb_cyc  = bus_active;
    assign bus.wb_stb  = (bstate == B_REQ);
    assign bus.wb_we   = bus_active;
    assign bus.wb_sel  = {4{bus_active}};
    assign bus.wb_addr = addr;
    assign bus.wb_data = data;
    assign o_cpu_hold  = cpu_hold;
    assign o_err       = err;
    assign o_busy      = (state != S_IDLE) || bus_active;
endmodule

// File: tb/tb_uart_wb_loader.sv
// Bench for uart_wb_loader: directed frames plus randomized WRITE frames
// against a frame-level write-list model and a configurable Wishbone slave.
module tb_uart_wb_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_hold, busy;
    logic [1:0] err;

    uart_wb_loader_if bus_if();

    uart_wb_loader #(
        .BYTE_TIMEOUT (100),
        .ACK_TIMEOUT  (16),
        .HOLD_AT_RESET(1'b1)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus_if),
        .o_cpu_hold(cpu_hold),
        .o_busy    (busy),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        we;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  checks = 0;
    int  errors = 0;
    int  stb_cnt = 0;
    int  cyc_cnt = 0;
    int  late_cnt = 0;
    int  stall_cycles = 0;
    int  ack_delay = 0;
    bit  never_ack = 1'b0;

    // Slave: stalls a fresh stb for stall_cycles, then acks ack_delay cycles after acceptance.
    initial begin
        int st, ad;
        bit in_txn, acc;
        in_txn = 1'b0; acc = 1'b0; st = 0; ad = -1;
        bus_if.wb_stall = 1'b0;
        bus_if.wb_ack   = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus_if.wb_stall = 1'b0;
            bus_if.wb_ack   = 1'b0;
            if (!bus_if.wb_cyc) begin
                in_txn = 1'b0;
            end else begin
                if (bus_if.wb_stb && !in_txn) begin
                    in_txn = 1'b1; acc = 1'b0; st = stall_cycles; ad = ack_delay;
                end
                if (in_txn && !acc) begin
                    if (st > 0) begin bus_if.wb_stall = 1'b1; st--; end
                    else acc = 1'b1;
                end
                if (in_txn && acc && !never_ack && ad >= 0) begin
                    if (ad == 0) bus_if.wb_ack = 1'b1;
                    ad--;
                end
            end
        end
    end

    initial begin
        wr_t o;
        bit  prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.wb_stb) stb_cnt++;
            if (bus_if.wb_cyc) cyc_cnt++;
            if (prev_ack && bus_if.wb_cyc) late_cnt++;
            prev_ack = bus_if.wb_ack;
            if (bus_if.wb_cyc && bus_if.wb_stb && !bus_if.wb_stall) begin
                o.addr = bus_if.wb_addr; o.data = bus_if.wb_data;
                o.sel  = bus_if.wb_sel;  o.we   = bus_if.wb_we;
                obs_q.push_back(o);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        checks++;
        assert (obsv === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obsv, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        bus_if.byte_rx_data  = b;
        bus_if.byte_rx_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.byte_rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a; e.data = d; e.sel = 4'hF; e.we = 1'b1;
        exp_q.push_back(e);
    endtask

    // WRITE frame with random data; the model expects word i at (base & ~3) + 4*i.
    task automatic send_write(input logic [31:0] a, input int n, input int gap);
        logic [31:0] w, t;
        logic [15:0] cnt;
        cnt = 16'(n);
        send_byte(8'hA5, gap);
        send_byte(8'h01, gap);
        for (int k = 0; k < 4; k++) begin
            t = a >> (8 * k);
            send_byte(t[7:0], gap);
        end
        send_byte(cnt[7:0], gap);
        send_byte(cnt[15:8], gap);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            push_exp((a & 32'hFFFF_FFFC) + 32'(4 * i), w);
            for (int k = 0; k < 4; k++) begin
                t = w >> (8 * k);
                send_byte(t[7:0], gap);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, " busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, " n_writes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), obs_q[i].addr, exp_q[i].addr);
            check($sformatf("%s data[%0d]", tag, i), obs_q[i].data, exp_q[i].data);
            check($sformatf("%s sel[%0d]", tag, i), {28'b0, obs_q[i].sel}, {28'b0, exp_q[i].sel});
            check($sformatf("%s we[%0d]", tag, i), {31'b0, obs_q[i].we}, {31'b0, exp_q[i].we});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] frame_a [16];
        bus_if.byte_rx_data  = 8'h00;
        bus_if.byte_rx_valid = 1'b0;
        frame_a = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
                    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst cyc",  {31'b0, bus_if.wb_cyc}, 32'd0);
        check("rst stb",  {31'b0, bus_if.wb_stb}, 32'd0);
        check("rst we",   {31'b0, bus_if.wb_we}, 32'd0);
        check("rst addr", bus_if.wb_addr, 32'd0);
        check("rst data", bus_if.wb_data, 32'd0);
        check("rst sel",  {28'b0, bus_if.wb_sel}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst err",  {30'b0, err}, 32'd0);
        check("rst hold", {31'b0, cpu_hold}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two-word frame, zero-wait slave acking in the accepting cycle.
        stall_cycles = 0; ack_delay = 0; never_ack = 1'b0; late_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            send_byte(frame_a[i], 1);
            if (i == 0) begin
                @(negedge clk);
                check("A busy_in_frame", {31'b0, busy}, 32'd1);
            end
        end
        push_exp(32'h0000_0000, 32'h4433_2211);
        push_exp(32'h0000_0004, 32'h8877_6655);
        wait_idle("A");
        check_writes("A");
        check("A err",  {30'b0, err}, 32'd0);
        check("A hold", {31'b0, cpu_hold}, 32'd1);
        check("A late", late_cnt, 32'd0);

        send_byte(8'hA5, 1);
        send_byte(8'h02, 0);
        @(negedge clk);
        check("RUN hold", {31'b0, cpu_hold}, 32'd0);
        wait_idle("RUN");
        check_writes("RUN");

        send_byte(8'hA5, 1);
        send_byte(8'h07, 0);
        @(negedge clk);
        check("BAD err",  {30'b0, err}, 32'd1);
        check("BAD busy", {31'b0, busy}, 32'd0);
        send_byte(8'hA5, 0);
        @(negedge clk);
        check("SYNC clears err", {30'b0, err}, 32'd0);
        send_byte(8'h01, 0);
        for (int k = 0; k < 6; k++) send_byte(8'h00, 0);
        wait_idle("CNT0");
        check_writes("CNT0");
        check("CNT0 hold", {31'b0, cpu_hold}, 32'd1);

        // Stalled slave: 5 stall cycles, ack 3 cycles after acceptance.
        stall_cycles = 5; ack_delay = 3; stb_cnt = 0; late_cnt = 0;
        send_write(32'h0000_1000, 1, 1);
        wait_idle("STALL");
        check("STALL stb_cycles", stb_cnt, 32'd6);
        check("STALL late", late_cnt, 32'd0);
        check_writes("STALL");

        for (int r = 0; r < 6; r++) begin
            stall_cycles = $urandom_range(0, 3);
            ack_delay    = $urandom_range(0, 3);
            late_cnt     = 0;
            send_write($urandom, $urandom_range(1, 4), $urandom_range(1, 3));
            wait_idle($sformatf("RND%0d", r));
            check_writes($sformatf("RND%0d", r));
            check($sformatf("RND%0d err", r), {30'b0, err}, 32'd0);
            check($sformatf("RND%0d late", r), late_cnt, 32'd0);
        end

        stall_cycles = 0; ack_delay = 1;
        send_write(32'hFFFF_FFF9, 3, 1);
        wait_idle("WRAP");
        check_writes("WRAP");

        // Slave that accepts but never acks.
        stall_cycles = 0; ack_delay = 0; never_ack = 1'b1; cyc_cnt = 0;
        send_write(32'h0000_2000, 1, 1);
        wait_idle("ACKTO");
        check("ACKTO cyc_cycles", cyc_cnt, 32'd16);
        check("ACKTO err", {30'b0, err}, 32'd3);
        check("ACKTO cyc", {31'b0, bus_if.wb_cyc}, 32'd0);
        check_writes("ACKTO");
        never_ack = 1'b0;

        // Second word completes while the first is still stalled.
        stall_cycles = 10;
        send_write(32'h0000_3000, 2, 0);
        wait_idle("OVR");
        check("OVR err", {30'b0, err}, 32'd3);
        exp_q.delete();
        check_writes("OVR");

        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        for (int k = 0; k < 4; k++) send_byte(8'h40, 0);
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("BTO err_before", {30'b0, err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("BTO err", {30'b0, err}, 32'd2);
        check("BTO busy", {31'b0, busy}, 32'd0);

        stall_cycles = 10;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
        @(negedge clk);
        check("RST pre cyc", {31'b0, bus_if.wb_cyc}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("RST cyc",  {31'b0, bus_if.wb_cyc}, 32'd0);
        check("RST err",  {30'b0, err}, 32'd0);
        check("RST hold", {31'b0, cpu_hold}, 32'd1);
        check("RST busy", {31'b0, busy}, 32'd0);
        check("RST addr", bus_if.wb_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check_writes("RST");

        send_byte(8'hA5, 1);
        send_byte(8'h02, 0);
        @(negedge clk);
        check("RUN2 hold", {31'b0, cpu_hold}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("RST2 hold", {31'b0, cpu_hold}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
